// File: rtl/if_id_buf.sv
// Fetch-to-decode pipeline buffer: 2-entry skid FIFO with valid/ready on both sides.
// Flushes on taken jump/branch and presents a NOP to decode whenever it is empty.
module if_id_buf #(
  parameter logic [31:0] NOP_INST   = 32'h0000_0013,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] inst_i,
  input  logic        inst_valid_i,
  output logic        inst_ready_o,
  output logic [31:0] inst_addr_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  input  logic        flush_i
);

  // state | meaning
  // EMPTY | no valid entry, NOP presented to decode
  // HALF  | one entry, held at head
  // FULL  | two entries, fetch back-pressured
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_head;
  logic        w_head_nxt;
  logic [31:0] r_addr [2];
  logic [31:0] r_inst [2];

  logic        w_push;
  logic        w_pop;
  logic        w_tail;
  logic        w_wr;

  // Handshake outputs depend only on registered state.
  assign inst_ready_o = (r_state != FULL);
  assign inst_valid_o = (r_state != EMPTY);
  assign inst_addr_o  = inst_valid_o ? r_addr[r_head] : RESET_ADDR;
  assign inst_o       = inst_valid_o ? r_inst[r_head] : NOP_INST;

  assign w_push = inst_valid_i & inst_ready_o;
  assign w_pop  = inst_valid_o & inst_ready_i;
  assign w_tail = r_head ^ (r_state == HALF);
  assign w_wr   = w_push & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_head  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head ^ w_pop;
    if (flush_i) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_push) w_state_nxt = HALF;
        HALF: begin
          if (w_push && !w_pop)      w_state_nxt = FULL;
          else if (!w_push && w_pop) w_state_nxt = EMPTY;
        end
        FULL:    if (w_pop) w_state_nxt = HALF;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // In HALF with push+pop the new word lands opposite the head, which the pop then selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_addr[i] <= 32'h0;
        r_inst[i] <= 32'h0;
      end
    end else if (w_wr) begin
      r_addr[w_tail] <= inst_addr_i;
      r_inst[w_tail] <= inst_i;
    end
  end

endmodule

// File: tb/tb_if_id_buf.sv
// Directed bench for if_id_buf: streaming, stall fill, push+pop, flush, wrap and async reset.
module tb_if_id_buf;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_i;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        flush_i;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_id_buf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_addr_i  (inst_addr_i),
    .inst_i       (inst_i),
    .inst_valid_i (inst_valid_i),
    .inst_ready_o (inst_ready_o),
    .inst_addr_o  (inst_addr_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .flush_i      (flush_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic v, input logic [31:0] a, input logic [31:0] d);
    inst_valid_i = v;
    inst_addr_i  = a;
    inst_i       = d;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, {31'h0, inst_valid_o}, 32'h0);
    check({tag, "_inst"},  inst_o,                NOP);
    check({tag, "_addr"},  inst_addr_o,           32'h0);
    check({tag, "_ready"}, {31'h0, inst_ready_o}, 32'h1);
  endtask

  task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic rdy);
    check({tag, "_valid"}, {31'h0, inst_valid_o}, 32'h1);
    check({tag, "_addr"},  inst_addr_o,           a);
    check({tag, "_inst"},  inst_o,                d);
    check({tag, "_ready"}, {31'h0, inst_ready_o}, {31'h0, rdy});
  endtask

  logic [31:0] next_push;
  logic [31:0] next_pop;

  initial begin
    rst_n = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    inst_ready_i = 1'b0;
    flush_i      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_empty("reset");

    // streaming with decode always ready
    inst_ready_i = 1'b1;
    offer(1'b1, 32'h0, 32'h0010_0093); tick();
    check_head("str0", 32'h0, 32'h0010_0093, 1'b1);
    offer(1'b1, 32'h4, 32'h0020_0113); tick();
    check_head("str1", 32'h4, 32'h0020_0113, 1'b1);
    offer(1'b1, 32'h8, 32'h0020_81B3); tick();
    check_head("str2", 32'h8, 32'h0020_81B3, 1'b1);
    offer(1'b0, 32'h0, 32'h0); tick();
    check_empty("str_drain");

    // stall fill and release
    inst_ready_i = 1'b0;
    offer(1'b1, 32'h10, 32'hA000_0010); tick();
    check_head("fill0", 32'h10, 32'hA000_0010, 1'b1);
    offer(1'b1, 32'h14, 32'hA000_0014); tick();
    check_head("fill_full", 32'h10, 32'hA000_0010, 1'b0);
    offer(1'b1, 32'h18, 32'hA000_0018); tick();
    check_head("fill_hold", 32'h10, 32'hA000_0010, 1'b0);
    inst_ready_i = 1'b1; tick();
    check_head("rel0", 32'h14, 32'hA000_0014, 1'b1);
    tick();
    check_head("rel1", 32'h18, 32'hA000_0018, 1'b1);
    offer(1'b0, 32'h0, 32'h0); tick();
    check_empty("rel_drain");

    // push + pop in HALF
    inst_ready_i = 1'b0;
    offer(1'b1, 32'h20, 32'hB000_0020); tick();
    check_head("pp0", 32'h20, 32'hB000_0020, 1'b1);
    inst_ready_i = 1'b1;
    offer(1'b1, 32'h24, 32'hB000_0024); tick();
    check_head("pp1", 32'h24, 32'hB000_0024, 1'b1);
    offer(1'b0, 32'h0, 32'h0); tick();
    check_empty("pp_drain");

    // flush from FULL with an offered instruction
    inst_ready_i = 1'b0;
    offer(1'b1, 32'h30, 32'hC000_0030); tick();
    offer(1'b1, 32'h34, 32'hC000_0034); tick();
    check_head("fl_full", 32'h30, 32'hC000_0030, 1'b0);
    offer(1'b1, 32'h38, 32'hC000_0038); flush_i = 1'b1; tick();
    flush_i = 1'b0;
    check_empty("fl_full_after");
    // flush discards a completed handshake in HALF
    offer(1'b1, 32'h40, 32'hC000_0040); tick();
    offer(1'b1, 32'h44, 32'hC000_0044); flush_i = 1'b1; tick();
    check_empty("fl_half_after");
    // flush held: everything offered dropped
    offer(1'b1, 32'h48, 32'hC000_0048); tick();
    check_empty("fl_held");
    flush_i = 1'b0;
    offer(1'b1, 32'h100, 32'hC000_0100); tick();
    check_head("fl_next", 32'h100, 32'hC000_0100, 1'b1);
    inst_ready_i = 1'b1;
    offer(1'b0, 32'h0, 32'h0); tick();
    check_empty("fl_alone");

    // wrap: continuous pushes, decode stalls two cycles then releases two
    next_push = 32'h200;
    next_pop  = 32'h200;
    for (int i = 0; i < 20; i++) begin
      inst_ready_i = i[1];
      offer(1'b1, next_push, next_push ^ 32'h5A5A_0000);
      if (inst_valid_o && inst_ready_i) begin
        check("wrap_addr", inst_addr_o, next_pop);
        check("wrap_inst", inst_o, next_pop ^ 32'h5A5A_0000);
        next_pop = next_pop + 32'h4;
      end
      if (inst_ready_o) next_push = next_push + 32'h4;
      tick();
    end
    offer(1'b0, 32'h0, 32'h0);
    inst_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (inst_valid_o) begin
        check("drain_addr", inst_addr_o, next_pop);
        next_pop = next_pop + 32'h4;
      end
      tick();
    end
    check("wrap_total", next_pop, next_push);
    check_empty("wrap_end");

    // asynchronous reset mid-cycle with FULL buffer
    inst_ready_i = 1'b0;
    offer(1'b1, 32'h50, 32'hD000_0050); tick();
    offer(1'b1, 32'h54, 32'hD000_0054); tick();
    offer(1'b0, 32'h0, 32'h0);
    check_head("ar_full", 32'h50, 32'hD000_0050, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_empty("ar_now");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_empty("ar_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
- Fetch-to-decode pipeline buffer, directly upstream of the decode stage.
- Replaces a plain if_id flop pair with a 2-entry skid FIFO using valid/ready on both sides, so fetch can keep streaming while decode is held.
- Flushes on taken jump/branch.
- Presents a NOP to decode whenever it holds no valid instruction.

Parameters:
- NOP_INST, 32'h0000_0013, instruction driven on inst_o when buffer empty (addi x0,x0,0).
- RESET_ADDR, 32'h0000_0000, value driven on inst_addr_o when buffer empty.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inst_addr_i  in  32  PC of incoming fetched instruction.
- inst_i  in  32  incoming fetched instruction word.
- inst_valid_i  in  1  fetch offers inst_i/inst_addr_i this cycle.
- inst_ready_o  out  1  buffer can accept this cycle.
- inst_addr_o  out  32  PC of head entry, to decode.
- inst_o  out  32  instruction of head entry, to decode.
- inst_valid_o  out  1  head entry valid.
- inst_ready_i  in  1  decode consumes head this cycle (low = hold).
- flush_i  in  1  taken jump/branch; discard all buffered and incoming instructions.

Behaviour:
- Storage: 2 entries of {addr[31:0], inst[31:0]}, head pointer (1 bit), count[1:0]. States: EMPTY (count 0), HALF (count 1), FULL (count 2).
- Push = inst_valid_i & inst_ready_o. Pop = inst_valid_o & inst_ready_i.
- Output timing:
  - inst_ready_o = (count != 2), decoded from registered state only; no combinational path from inst_ready_i.
  - inst_o/inst_addr_o/inst_valid_o come from registered head entry; no combinational path from inst_i/inst_addr_i.
  - Latency: instruction pushed at edge N is visible on outputs after edge N (next cycle) when it becomes head.
- Empty outputs: inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=RESET_ADDR.
- Reset (rst_n=0, asynchronous, immediate): count=0, head=0, all entries cleared, so inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=RESET_ADDR, inst_ready_o=1. Reset mid-stream drops everything without waiting for a clock.
- Transitions, flush_i=0:
  - EMPTY: push -> HALF, entry holds new instr. No push -> stay. Pop impossible (valid=0).
  - HALF: push only -> FULL, new instr behind head. Pop only -> EMPTY. Push+pop -> HALF, new instr becomes head next cycle.
  - FULL: inst_ready_o=0, no push. Pop -> HALF, second entry becomes head. No pop -> hold, outputs stable.
- Order strictly FIFO; no entry lost or duplicated across any push/pop combination.
- Flush (synchronous, highest priority):
  - At edge with flush_i=1: count->0 regardless of push/pop. The instruction offered that cycle is discarded even if the handshake completed.
  - Next cycle: outputs show NOP_INST/RESET_ADDR, valid=0, inst_ready_o=1.
  - A pop in the flush cycle still counts as consumed by decode. Flush in EMPTY is harmless.
  - flush_i held multiple cycles: buffer stays EMPTY, all offered instructions dropped.
- Pointer wrap: head toggles on each pop; tail index = head ^ (count==1). Back-to-back push+pop wraps indefinitely.
- No X propagation: entry contents are don't-care when not valid, but outputs are forced to NOP_INST/RESET_ADDR when count=0.

Test Plan:
- Reset / idle: assert rst_n=0 mid-cycle with FULL buffer -> immediately inst_valid_o=0, inst_o=32'h00000013, inst_addr_o=0, inst_ready_o=1.
- Streaming: inst_ready_i=1, push addr 0x0/0x4/0x8 with insts 0x00100093/0x00200113/0x002081B3 on consecutive cycles -> same sequence on outputs one cycle later each, count never exceeds 1, inst_ready_o stays 1.
- Stall fill: inst_ready_i=0, push 0x10 then 0x14 -> FULL, inst_ready_o=0, output holds addr 0x10. Offer 0x18 -> not accepted. Release inst_ready_i -> outputs 0x10, 0x14, then 0x18 accepted and output in order.
- Simultaneous push+pop in HALF: head 0x20, push 0x24 while popping -> next cycle head=0x24, count=1, inst_ready_o=1.
- Flush: FULL (0x30, 0x34) with 0x38 offered and flush_i=1 -> next cycle inst_valid_o=0, inst_o=NOP_INST. 0x38 never appears. Next push 0x100 appears alone one cycle later.
- Wrap: 20 cycles alternating stall/release with continuous pushes -> output address sequence is monotonic +4 with no gaps or duplicates.
